mac_array_seq: RTL
==================

Name: mac_array_seq

Overview:
- Job sequencer for the 2x2 mac_array: clears the accumulators, streams a run of activations into a_in, and drives the per-MAC 3-bit valid_ctrl enables.
- Waits for the array pipeline to drain, then signals completion to the host/control FSM.
- Sits between an activation source (valid/ready stream) and mac_array; weights are static during a job and are driven by a separate path.

Parameters:
- N_MACS, 4, number of MACs controlled; clear width is N_MACS, valid_ctrl width is 3*N_MACS.
- ACC_W, 16, activation/accumulator data width.
- LEN_W, 8, width of the job length field (max 255 beats).
- DRAIN_CYC, 3, idle cycles after the last beat before done; must be >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- abort  in  1  cancels the current job.
- cfg_len  in  LEN_W  number of activation beats; latched on accepted start.
- cfg_mode  in  3*N_MACS  valid_ctrl pattern applied on every beat; latched on accepted start.
- act_valid  in  1  activation source valid.
- act_ready  out  1  activation source ready.
- act_data  in  ACC_W  activation, signed.
- arr_a_in  out  ACC_W  to mac_array a_in, registered.
- arr_valid_ctrl  out  3*N_MACS  to mac_array valid_ctrl, registered.
- arr_clear  out  N_MACS  to mac_array clear.
- arr_valid_out  in  N_MACS  from mac_array valid_out.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- res_mask  out  N_MACS  sticky OR of arr_valid_out over the job; valid while done=1.

Behaviour:
- Clocking and reset: single clock clk. rst is synchronous, active-high, and forces IDLE.
- Reset values: act_ready=0, arr_a_in=0, arr_valid_ctrl=0, arr_clear=0, busy=0, done=0, res_mask=0, beat counter=0, drain counter=0, latched len=0, latched mode=0.
- State machine: IDLE, CLEAR, STREAM, DRAIN, DONE. act_ready, arr_clear, busy and done are decoded from the state register.
- IDLE:
  - start=1 latches cfg_len and cfg_mode, clears res_mask and the counters, and moves to CLEAR.
  - start=1 and abort=1 in the same cycle: abort wins and start is ignored.
- CLEAR (exactly 1 cycle):
  - arr_clear = all ones; arr_valid_ctrl = 0.
  - Next state is STREAM if len!=0, else DRAIN. A zero-length job yields cleared accumulators and a normal done.
- STREAM:
  - act_ready=1; a beat is act_valid & act_ready.
  - On a beat: arr_a_in <= act_data, arr_valid_ctrl <= latched mode (visible the next cycle, 1-cycle latency), beat counter +1.
  - On a non-beat cycle: arr_valid_ctrl <= 0 and arr_a_in holds its value.
  - On the beat where counter == len-1: move to DRAIN with the counter reset. Extra act_valid after this beat is not accepted.
- DRAIN:
  - act_ready=0; arr_valid_ctrl <= 0 (the last beat's pattern is still visible during the first DRAIN cycle, by latency).
  - Lasts DRAIN_CYC cycles, then DONE.
- DONE (1 cycle): done=1, busy=1, res_mask stable. Next state is IDLE; a start in that cycle is ignored.
- res_mask: res_mask |= arr_valid_out every cycle in STREAM and DRAIN. It is not cleared until the next accepted start, so it remains readable after done.
- Abort / busy start:
  - start while busy is ignored.
  - abort=1 in CLEAR, STREAM or DRAIN: next cycle is IDLE. No done pulse. arr_valid_ctrl <= 0; arr_a_in and res_mask hold.
  - abort in DONE still lets done complete.
  - abort or rst mid-STREAM discards any partially consumed run; the accumulators are not cleared until the next job.
- Timing:
  - Minimum job duration from the start cycle to the done cycle is 1 + 1 + len + DRAIN_CYC cycles with act_valid held high.
  - Source stalls extend STREAM one-for-one.
- Widths: all length/counter compares are unsigned LEN_W. Data passes through unmodified, with no sign or width change.

Test Plan:
- Basic job: rst, then start with cfg_len=4 and cfg_mode=12'h249, act_valid held high with data 1,2,3,4 -> arr_clear=4'hF for 1 cycle, act_ready high for exactly 4 cycles, arr_valid_ctrl=12'h249 on 4 consecutive cycles with arr_a_in=1..4, done pulse at cycle 9 after start (DRAIN_CYC=3), busy low the cycle after.
- Stalls: cfg_len=3 with act_valid pattern 1,0,0,1,0,1 -> arr_valid_ctrl nonzero only on the 3 cycles after accepted beats, arr_a_in holds 1 through the gaps, done 3+1 cycles after the third beat.
- Zero length: start with cfg_len=0 -> CLEAR 1 cycle, act_ready never asserted, arr_valid_ctrl stays 0, done 1+DRAIN_CYC+1 cycles after start.
- Abort mid-stream: cfg_len=8, abort after the 3rd beat -> act_ready low and busy low the next cycle, no done ever, arr_valid_ctrl=0; a following start with cfg_len=2 completes normally.
- Busy start and reset: assert start during STREAM -> ignored (latched len unchanged, done after the original len). Assert rst mid-DRAIN -> all outputs return to reset values next cycle, no done.
- res_mask: drive arr_valid_out=4'b0101 in one DRAIN cycle and 4'b0010 in another -> res_mask=4'b0111 during done. It is cleared to 0 on the next accepted start.

Source files
------------

// File: rtl/mac_array_seq.sv
// Job sequencer for a 2x2 mac_array: clears the accumulators, streams a run
// of activations into a_in with a per-job valid_ctrl pattern, waits for the
// array pipeline to drain, then pulses done and holds the sticky result mask.
module mac_array_seq #(
  parameter int N_MACS    = 4,
  parameter int ACC_W     = 16,
  parameter int LEN_W     = 8,
  parameter int DRAIN_CYC = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic [3*N_MACS-1:0]   cfg_mode,
  input  logic                  act_valid,
  output logic                  act_ready,
  input  logic [ACC_W-1:0]      act_data,
  output logic [ACC_W-1:0]      arr_a_in,
  output logic [3*N_MACS-1:0]   arr_valid_ctrl,
  output logic [N_MACS-1:0]     arr_clear,
  input  logic [N_MACS-1:0]     arr_valid_out,
  output logic                  busy,
  output logic                  done,
  output logic [N_MACS-1:0]     res_mask
);

  localparam int VC_W = 3 * N_MACS;
  localparam int DCW  = $clog2(DRAIN_CYC + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [VC_W-1:0]  mode_q, mode_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [ACC_W-1:0] a_in_q, a_in_d;
  logic [VC_W-1:0]  vc_q, vc_d;
  logic [N_MACS-1:0] mask_q, mask_d;
  logic             beat;

  // Handshake and host-visible status decoded straight from the state register
  assign act_ready = (state_q == S_STREAM);
  assign arr_clear = (state_q == S_CLEAR) ? {N_MACS{1'b1}} : {N_MACS{1'b0}};
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign beat      = act_valid & act_ready;

  assign arr_a_in       = a_in_q;
  assign arr_valid_ctrl = vc_q;
  assign res_mask       = mask_q;

  // Next-state and datapath decisions for the job sequence
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    mode_d      = mode_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    a_in_d      = a_in_q;
    vc_d        = '0;
    mask_d      = mask_q;

    case (state_q)
      S_IDLE: begin
        // abort in the same cycle as start suppresses the job
        if (start && !abort) begin
          len_d       = cfg_len;
          mode_d      = cfg_mode;
          mask_d      = '0;
          beat_cnt_d  = '0;
          drain_cnt_d = '0;
          state_d     = S_CLEAR;
        end
      end

      S_CLEAR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = (len_q != '0) ? S_STREAM : S_DRAIN;
        end
      end

      S_STREAM: begin
        // An abort drops any beat offered this cycle; a_in and mask hold
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          mask_d = mask_q | arr_valid_out;
          if (beat) begin
            a_in_d = act_data;
            vc_d   = mode_q;
            if (beat_cnt_q == len_q - LEN_W'(1)) begin
              beat_cnt_d = '0;
              state_d    = S_DRAIN;
            end else begin
              beat_cnt_d = beat_cnt_q + LEN_W'(1);
            end
          end
        end
      end

      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          mask_d = mask_q | arr_valid_out;
          if (drain_cnt_q == DCW'(DRAIN_CYC - 1)) begin
            drain_cnt_d = '0;
            state_d     = S_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q + DCW'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      mode_q      <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      a_in_q      <= '0;
      vc_q        <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      a_in_q      <= a_in_d;
      vc_q        <= vc_d;
      mask_q      <= mask_d;
    end
  end

endmodule
